uart_rx_ctrl: RTL
=================

// Module: uart_rx_ctrl
// PURPOSE
//  Controller that sits beside the UART receiver top level and owns its configuration and output path.
//  - Drives Prescale/PAR_EN/PAR_TYP into the receiver.
//  - Tracks frame activity so configuration changes are applied only between frames.
//  - Buffers received bytes in a first-word-fall-through FIFO with a valid/ready consumer handshake.
//  - Reports overflow and frame-timeout status.
// PARAMETERS
//  DEPTH         8   FIFO entries; power of two, 2..64
//  DEF_PRESCALE  8   Prescale value loaded at reset; must be >= 4
//  DEF_PAR_EN    1   PAR_EN value loaded at reset
//  DEF_PAR_TYP   0   PAR_TYP value loaded at reset (0 = even, 1 = odd)
// PORTS
//  clk           in   1   system clock; all logic on its rising edge
//  rst           in   1   asynchronous active-low reset
//  rx_in         in   1   serial line, same signal as the receiver's RX_IN (already synchronised)
//  rx_data_valid in   1   receiver byte-done pulse (one cycle)
//  rx_p_data     in   8   receiver parallel byte, qualified by rx_data_valid
//  cfg_wr        in   1   one-cycle configuration write strobe
//  cfg_prescale  in   6   requested Prescale
//  cfg_par_en    in   1   requested PAR_EN
//  cfg_par_typ   in   1   requested PAR_TYP
//  Prescale      out  6   to receiver
//  PAR_EN        out  1   to receiver
//  PAR_TYP       out  1   to receiver
//  cfg_pending   out  1   shadow config written but not yet applied
//  cfg_err       out  1   one-cycle pulse: write rejected (cfg_prescale < 4)
//  m_data        out  8   FIFO head byte
//  m_valid       out  1   FIFO non-empty
//  m_ready       in   1   consumer accepts m_data when m_valid && m_ready
//  fifo_count    out  clog2(DEPTH)+1   current occupancy
//  ovf           out  1   sticky: byte dropped because FIFO was full
//  tmo           out  1   sticky: frame timed out without rx_data_valid
//  sts_clr       in   1   clears ovf and tmo (a set event in the same cycle wins)
// BEHAVIOUR
//  Reset values:
//  - Prescale=DEF_PRESCALE, PAR_EN=DEF_PAR_EN, PAR_TYP=DEF_PAR_TYP.
//  - cfg_pending=0, cfg_err=0, m_valid=0, m_data=0, fifo_count=0, ovf=0, tmo=0.
//  - FSM in IDLE; rx_in_q=1.
//  Falling-edge detect: fall = rx_in_q & ~rx_in, where rx_in_q is rx_in registered.
//  FSM:
//  - IDLE -> FRAME on fall; timer loads 0.
//  - FRAME: timer increments every cycle.
//  - FRAME -> IDLE on rx_data_valid.
//  - FRAME -> IDLE when timer == 12*Prescale; set tmo. Limit is 10 bits, computed as (Prescale<<3)+(Prescale<<2).
//  - rx_data_valid while in IDLE is still pushed to the FIFO; no state change.
//  Config write:
//  - cfg_wr with cfg_prescale >= 4 latches all three fields into the shadow registers next cycle and sets cfg_pending.
//  - cfg_wr with cfg_prescale < 4 pulses cfg_err for one cycle; shadow and cfg_pending are unchanged.
//  - A later cfg_wr while pending overwrites the shadow (last write wins).
//  Apply:
//  - In a cycle with state==IDLE, cfg_pending=1 and fall=0, outputs take the shadow values next edge and cfg_pending clears.
//  - Outputs never change while state==FRAME, or in the cycle a frame starts.
//  FIFO (first-word fall-through):
//  - Push on rx_data_valid; pop on m_valid && m_ready.
//  - m_data = head entry; valid the same cycle m_valid rises. Push-to-m_valid latency is 1 cycle.
//  - Full with push and no pop: byte dropped, ovf set, contents unchanged.
//  - Full with push and pop together: both happen; count stays at DEPTH; no overflow.
//  - Empty with push and m_ready: no pop (m_valid=0); count becomes 1.
//  - Pointers wrap modulo DEPTH.
//  Mid-operation reset: every register returns to its reset value asynchronously; FIFO contents are discarded.
// TESTING
//  1. Reset -> Prescale=8, PAR_EN=1, PAR_TYP=0, m_valid=0, fifo_count=0.
//  2. Push 0xA5, 0x3C with m_ready=0 -> count=2, m_data=0xA5; raise m_ready -> 0xA5 then 0x3C popped; m_valid=0.
//  3. Fill 8 bytes, push 0x77 -> ovf=1, count=8, 0x77 never appears; push+pop when full -> count stays 8, ovf only via sts_clr.
//  4. fall, then cfg_wr(prescale=16) mid-frame -> cfg_pending=1, Prescale=8 until rx_data_valid, Prescale=16 one cycle after IDLE.
//  5. fall with no rx_data_valid at Prescale=8 -> tmo=1 after 96 cycles, FSM IDLE; sts_clr -> tmo=0.
//  6. cfg_wr(prescale=2) -> cfg_err one-cycle pulse, cfg_pending=0, Prescale unchanged.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Controller that sits beside the UART receiver. It owns the receiver's
// configuration (Prescale / PAR_EN / PAR_TYP), tracks frame activity so that
// configuration changes only take effect between frames, buffers received
// bytes in a first-word-fall-through FIFO and reports overflow / timeout.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   rx_in         serial line (already synchronised)
//   rx_data_valid receiver byte-done pulse
//   rx_p_data     receiver byte, qualified by rx_data_valid
//   cfg_wr        configuration write strobe
//   cfg_prescale  requested Prescale
//   cfg_par_en    requested PAR_EN
//   cfg_par_typ   requested PAR_TYP
//   Prescale      applied Prescale to the receiver
//   PAR_EN        applied parity enable
//   PAR_TYP       applied parity type (0 even, 1 odd)
//   cfg_pending   shadow configuration waiting to be applied
//   cfg_err       one-cycle pulse: write rejected (cfg_prescale < 4)
//   m_data        FIFO head byte (0 while empty)
//   m_valid       FIFO non-empty
//   m_ready       consumer accepts head when m_valid && m_ready
//   fifo_count    FIFO occupancy
//   ovf           sticky: byte dropped on a full FIFO
//   tmo           sticky: frame ended by timeout
//   sts_clr       clears ovf/tmo; a set event in the same cycle wins
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int         DEPTH        = 8,
  parameter logic [5:0] DEF_PRESCALE = 6'd8,
  parameter logic       DEF_PAR_EN   = 1'b1,
  parameter logic       DEF_PAR_TYP  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_in,
  input  logic                     rx_data_valid,
  input  logic [7:0]               rx_p_data,
  input  logic                     cfg_wr,
  input  logic [5:0]               cfg_prescale,
  input  logic                     cfg_par_en,
  input  logic                     cfg_par_typ,
  output logic [5:0]               Prescale,
  output logic                     PAR_EN,
  output logic                     PAR_TYP,
  output logic                     cfg_pending,
  output logic                     cfg_err,
  output logic [7:0]               m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     ovf,
  output logic                     tmo,
  input  logic                     sts_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  // registers
  logic          r_rx_in_q;
  state_t        r_state;
  logic [9:0]    r_timer;
  logic [5:0]    r_prescale;
  logic          r_par_en;
  logic          r_par_typ;
  logic [5:0]    r_sh_prescale;
  logic          r_sh_par_en;
  logic          r_sh_par_typ;
  logic          r_cfg_pending;
  logic          r_cfg_err;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_tmo;

  // combinational signals
  state_t        w_state_nxt;
  logic [9:0]    w_timer_nxt;
  logic          w_tmo_evt;
  logic          w_fall;
  logic [9:0]    w_limit;
  logic          w_apply;
  logic          w_cfg_ok;
  logic          w_cfg_bad;
  logic          w_empty;
  logic          w_full;
  logic          w_do_pop;
  logic          w_do_push;
  logic          w_ovf_evt;

  assign w_fall    = r_rx_in_q & ~rx_in;
  // 12 * Prescale without a multiplier; 63*12 still fits in 10 bits
  assign w_limit   = ({4'd0, r_prescale} << 3) + ({4'd0, r_prescale} << 2);
  // a frame starting this cycle blocks the apply so the receiver never sees
  // its configuration change under a frame
  assign w_apply   = (r_state == ST_IDLE) & r_cfg_pending & ~w_fall;
  assign w_cfg_ok  = cfg_wr & (cfg_prescale >= 6'd4);
  assign w_cfg_bad = cfg_wr & (cfg_prescale < 6'd4);

  assign w_empty   = (r_count == {CW{1'b0}});
  assign w_full    = (r_count == FULL_CNT);
  assign w_do_pop  = ~w_empty & m_ready;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign w_do_push = rx_data_valid & (~w_full | w_do_pop);
  assign w_ovf_evt = rx_data_valid & w_full & ~w_do_pop;

  // Register the serial line for falling-edge detection (idle line is high)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_in_q <= 1'b1;
    end else begin
      r_rx_in_q <= rx_in;
    end
  end

  // Frame FSM state and frame timer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_timer <= 10'd0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Frame FSM next-state, timer and timeout event
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_tmo_evt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_state_nxt = ST_FRAME;
          w_timer_nxt = 10'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FRAME: begin
        // a completed byte ends the frame even if the limit is reached now
        if (rx_data_valid) begin
          w_state_nxt = ST_IDLE;
        end else if (r_timer == w_limit) begin
          w_state_nxt = ST_IDLE;
          w_tmo_evt   = 1'b1;
        end else begin
          w_timer_nxt = r_timer + 10'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = 10'd0;
      end
    endcase
  end

  // Shadow configuration, applied configuration and pending flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prescale    <= DEF_PRESCALE;
      r_par_en      <= DEF_PAR_EN;
      r_par_typ     <= DEF_PAR_TYP;
      r_sh_prescale <= DEF_PRESCALE;
      r_sh_par_en   <= DEF_PAR_EN;
      r_sh_par_typ  <= DEF_PAR_TYP;
      r_cfg_pending <= 1'b0;
    end else begin
      // apply uses the shadow as it stood before any write in this cycle
      if (w_apply) begin
        r_prescale <= r_sh_prescale;
        r_par_en   <= r_sh_par_en;
        r_par_typ  <= r_sh_par_typ;
      end
      if (w_cfg_ok) begin
        r_sh_prescale <= cfg_prescale;
        r_sh_par_en   <= cfg_par_en;
        r_sh_par_typ  <= cfg_par_typ;
        r_cfg_pending <= 1'b1;
      end else if (w_apply) begin
        r_cfg_pending <= 1'b0;
      end else begin
        r_cfg_pending <= r_cfg_pending;
      end
    end
  end

  // One-cycle rejection pulse for an illegal Prescale write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_cfg_bad;
    end
  end

  // FIFO storage; contents are meaningless while the count says empty
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= rx_p_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= {AW{1'b0}};
      r_wr_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky status flags; a set event beats a clear in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
      r_tmo <= 1'b0;
    end else begin
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end else if (sts_clr) begin
        r_ovf <= 1'b0;
      end else begin
        r_ovf <= r_ovf;
      end
      if (w_tmo_evt) begin
        r_tmo <= 1'b1;
      end else if (sts_clr) begin
        r_tmo <= 1'b0;
      end else begin
        r_tmo <= r_tmo;
      end
    end
  end

  assign Prescale    = r_prescale;
  assign PAR_EN      = r_par_en;
  assign PAR_TYP     = r_par_typ;
  assign cfg_pending = r_cfg_pending;
  assign cfg_err     = r_cfg_err;
  assign m_valid     = ~w_empty;
  assign m_data      = w_empty ? 8'd0 : r_mem[r_rd_ptr];
  assign fifo_count  = r_count;
  assign ovf         = r_ovf;
  assign tmo         = r_tmo;

endmodule
